// File: rtl/bist_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bist_pkg : shared state encoding and Galois LFSR helpers for BIST
// Rev 1.0
// ------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_t;

  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;
  localparam logic [7:0] MISR_TAPS_8 = 8'hB8;

  localparam int GALOIS_MAX_W = 32;

  // Callers zero-extend narrower registers; upper bits stay zero through the step.
  function automatic logic [GALOIS_MAX_W-1:0] galois_step(
    input logic [GALOIS_MAX_W-1:0] s,
    input logic [GALOIS_MAX_W-1:0] taps
  );
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_lfsr.sv
`default_nettype none
// ------------------------------------------------------------------
// bist_lfsr : Galois LFSR / MISR register with load, enable and data injection
// Rev 1.0
// ------------------------------------------------------------------
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS_8),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] next_val;

  assign next_val = WIDTH'(galois_step(GALOIS_MAX_W'(state), GALOIS_MAX_W'(TAPS))) ^ data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= load_val;
    end else if (en) begin
      state <= next_val;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bist_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// bist_controller : sequenced LFSR pattern BIST with compare or MISR check
// Rev 1.0
// ------------------------------------------------------------------
module bist_controller
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               NUM_PATTERNS = 255,
  parameter logic [WIDTH-1:0] LFSR_TAPS    = WIDTH'(LFSR_TAPS_8),
  parameter logic [WIDTH-1:0] MISR_TAPS    = WIDTH'(MISR_TAPS_8),
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0,
  localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] dut_result,
  input  logic [WIDTH-1:0] ref_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    fail_count,
  output logic [CW-1:0]    first_fail,
  output logic [WIDTH-1:0] signature
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CW-1:0]    LAST_IDX = CW'(NUM_PATTERNS - 1);

  bist_state_t   state;
  logic          mode_q;
  logic [CW-1:0] idx;
  logic          launch;
  logic          running;

  // Run setup (LFSR/MISR load, counters cleared) happens on the edge entering SEED.
  assign launch  = start && !abort && (state == ST_IDLE || state == ST_DONE);
  assign running = (state == ST_RUN);

  bist_lfsr #(
    .WIDTH     (WIDTH),
    .TAPS      (LFSR_TAPS),
    .RESET_VAL (SEED_EFF)
  ) u_pattern_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .load_val (SEED_EFF),
    .en       (running),
    .data     ({WIDTH{1'b0}}),
    .state    (pattern)
  );

  bist_lfsr #(
    .WIDTH     (WIDTH),
    .TAPS      (MISR_TAPS),
    .RESET_VAL ({WIDTH{1'b0}})
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .load_val ({WIDTH{1'b0}}),
    .en       (running),
    .data     (dut_result),
    .state    (signature)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mode_q     <= 1'b0;
      idx        <= '0;
      fail_count <= '0;
      first_fail <= '1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state      <= ST_SEED;
            mode_q     <= mode;
            idx        <= '0;
            fail_count <= '0;
            first_fail <= '1;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        ST_SEED: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (!mode_q && dut_result != ref_result) begin
            if (fail_count == '0) first_fail <= idx;
            if (fail_count != '1) fail_count <= fail_count + CW'(1);
          end
          if (idx == LAST_IDX) begin
            state <= ST_CHECK;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        ST_CHECK: begin
          pass  <= mode_q ? (signature == GOLDEN_SIG) : (fail_count == '0);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bist_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bist_controller : randomized self-checking bench for bist_controller
// Rev 1.0
// ------------------------------------------------------------------
module tb_bist_controller;

  localparam int         N    = 255;
  localparam logic [7:0] TAPS = 8'hB8;

  function automatic logic [7:0] gstep(input logic [7:0] s);
    return (s >> 1) ^ (((s & 8'h01) != 8'h00) ? TAPS : 8'h00);
  endfunction

  // Signature of a clean run where the DUT echoes the pattern.
  function automatic logic [7:0] golden_fn();
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h01;
    m = 8'h00;
    for (int i = 0; i < N; i++) begin
      m = gstep(m) ^ p;
      p = gstep(p);
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD = golden_fn();

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       mode;
  logic [7:0] pattern;
  logic [7:0] dut_result;
  logic [7:0] ref_result;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_count;
  logic [7:0] first_fail;
  logic [7:0] signature;

  logic [7:0] pat_seq [N];
  logic [7:0] idx_of  [256];
  logic [7:0] mask    [256];
  logic       dut_sel;
  int         errors;
  int         checks;

  assign ref_result = pattern + 8'd1;
  assign dut_result = (dut_sel ? pattern : ref_result) ^ mask[idx_of[pattern]];

  bist_controller #(
    .WIDTH        (8),
    .NUM_PATTERNS (N),
    .LFSR_TAPS    (8'hB8),
    .MISR_TAPS    (8'hB8),
    .SEED         (8'h01),
    .GOLDEN_SIG   (GOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .pattern    (pattern),
    .dut_result (dut_result),
    .ref_result (ref_result),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .first_fail (first_fail),
    .signature  (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mask();
    for (int i = 0; i < 256; i++) mask[i] = 8'h00;
  endtask

  task automatic random_mask(input int one_in);
    clear_mask();
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, one_in - 1) == 0) mask[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic model(input logic m, output logic [7:0] e_fc, output logic [7:0] e_ff,
                       output logic [7:0] e_sig, output logic e_pass);
    logic [7:0] d;
    logic [7:0] r;
    int         nf;
    nf    = 0;
    e_ff  = 8'hFF;
    e_sig = 8'h00;
    for (int i = 0; i < N; i++) begin
      r     = pat_seq[i] + 8'd1;
      d     = (dut_sel ? pat_seq[i] : r) ^ mask[i];
      e_sig = gstep(e_sig) ^ d;
      if (!m && d != r) begin
        if (nf == 0) e_ff = 8'(i);
        nf++;
      end
    end
    e_fc   = 8'(nf > 255 ? 255 : nf);
    e_pass = m ? (e_sig == GOLD) : (nf == 0);
  endtask

  // Starts a run at the next edge and waits (bounded) for done; mode is flipped after start.
  task automatic do_run(input logic m, input int poke, output int done_cyc,
                        output int pat_err, output logic busy1);
    done_cyc = -1;
    pat_err  = 0;
    busy1    = 1'b0;
    mode     = m;
    start    = 1'b1;
    for (int cyc = 1; cyc <= N + 10; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == poke);
      mode  = ~m;
      if (cyc == 1) busy1 = busy;
      if (cyc >= 2 && cyc <= N + 1 && pattern !== pat_seq[cyc-2]) pat_err++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    mode  = m;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (pattern !== 8'h01) begin errors++; $display("FAIL reset_pattern: got %h expected 01", pattern); end
    checks++; if (signature !== 8'h00) begin errors++; $display("FAIL reset_signature: got %h expected 00", signature); end
    checks++; if (fail_count !== 8'h00) begin errors++; $display("FAIL reset_fail_count: got %h expected 00", fail_count); end
    checks++; if (first_fail !== 8'hFF) begin errors++; $display("FAIL reset_first_fail: got %h expected ff", first_fail); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/pass=%b expected 000", {busy, done, pass}); end
  endtask

  task automatic test_compare_pass();
    int         dc;
    int         pe;
    logic       b1;
    logic [7:0] e_fc, e_ff, e_sig;
    logic       e_pass;
    dut_sel = 1'b0;
    clear_mask();
    model(1'b0, e_fc, e_ff, e_sig, e_pass);
    do_run(1'b0, 0, dc, pe, b1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %b expected 1", b1); end
    checks++; if (pe != 0) begin errors++; $display("FAIL pattern_seq: got %0d wrong patterns expected 0", pe); end
    checks++; if (dc != N + 3) begin errors++; $display("FAIL done_cycle: got %0d expected %0d", dc, N + 3); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL cmp_pass: got %b expected 1", pass); end
    checks++; if (fail_count !== 8'h00) begin errors++; $display("FAIL cmp_fail_count: got %h expected 00", fail_count); end
    checks++; if (first_fail !== 8'hFF) begin errors++; $display("FAIL cmp_first_fail: got %h expected ff", first_fail); end
    checks++; if (signature !== e_sig) begin errors++; $display("FAIL cmp_signature: got %h expected %h", signature, e_sig); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
  endtask

  task automatic test_compare_fail();
    int   dc;
    int   pe;
    logic b1;
    dut_sel = 1'b0;
    clear_mask();
    mask[3]  = 8'($urandom_range(1, 255));
    mask[10] = 8'($urandom_range(1, 255));
    do_run(1'b0, 0, dc, pe, b1);
    checks++; if (fail_count !== 8'd2) begin errors++; $display("FAIL two_fail_count: got %0d expected 2", fail_count); end
    checks++; if (first_fail !== 8'd3) begin errors++; $display("FAIL two_first_fail: got %0d expected 3", first_fail); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL two_pass: got %b expected 0", pass); end
  endtask

  task automatic test_random_compare();
    int         dc;
    int         pe;
    logic       b1;
    logic [7:0] e_fc, e_ff, e_sig;
    logic       e_pass;
    dut_sel = 1'b0;
    for (int t = 0; t < 3; t++) begin
      random_mask(t == 0 ? 64 : 12);
      model(1'b0, e_fc, e_ff, e_sig, e_pass);
      do_run(1'b0, (t == 1) ? 40 : 0, dc, pe, b1);
      checks++; if (dc != N + 3) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", t, dc, N + 3); end
      checks++; if (fail_count !== e_fc) begin errors++; $display("FAIL rnd%0d_fail_count: got %0d expected %0d", t, fail_count, e_fc); end
      checks++; if (first_fail !== e_ff) begin errors++; $display("FAIL rnd%0d_first_fail: got %0d expected %0d", t, first_fail, e_ff); end
      checks++; if (pass !== e_pass) begin errors++; $display("FAIL rnd%0d_pass: got %b expected %b", t, pass, e_pass); end
      checks++; if (signature !== e_sig) begin errors++; $display("FAIL rnd%0d_signature: got %h expected %h", t, signature, e_sig); end
    end
  endtask

  task automatic test_signature();
    int         dc;
    int         pe;
    logic       b1;
    logic [7:0] e_fc, e_ff, e_sig;
    logic       e_pass;
    dut_sel = 1'b1;
    clear_mask();
    do_run(1'b1, 0, dc, pe, b1);
    checks++; if (signature !== GOLD) begin errors++; $display("FAIL sig_clean_value: got %h expected %h", signature, GOLD); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL sig_clean_pass: got %b expected 1", pass); end
    mask[100] = 8'h01 << $urandom_range(0, 7);
    model(1'b1, e_fc, e_ff, e_sig, e_pass);
    do_run(1'b1, 0, dc, pe, b1);
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL sig_flip_pass: got %b expected 0", pass); end
    checks++; if (signature !== e_sig) begin errors++; $display("FAIL sig_flip_value: got %h expected %h", signature, e_sig); end
    checks++; if (fail_count !== 8'h00) begin errors++; $display("FAIL sig_fail_count: got %h expected 00", fail_count); end
    dut_sel = 1'b0;
    random_mask(20);
    model(1'b1, e_fc, e_ff, e_sig, e_pass);
    do_run(1'b1, 0, dc, pe, b1);
    checks++; if (signature !== e_sig) begin errors++; $display("FAIL sig_rnd_value: got %h expected %h", signature, e_sig); end
    checks++; if (pass !== e_pass) begin errors++; $display("FAIL sig_rnd_pass: got %b expected %b", pass, e_pass); end
    checks++; if (first_fail !== 8'hFF) begin errors++; $display("FAIL sig_first_fail: got %h expected ff", first_fail); end
  endtask

  task automatic test_abort();
    dut_sel = 1'b0;
    clear_mask();
    mode  = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 52; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 20);
    end
    start = 1'b0;
    checks++; if (pattern !== pat_seq[50]) begin errors++; $display("FAIL abort_idx50_pattern: got %h expected %h", pattern, pat_seq[50]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL abort_flags: got busy/done/pass=%b expected 000", {busy, done, pass}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_idle_hold: got busy/done=%b expected 00", {busy, done}); end
  endtask

  task automatic test_reset_midrun();
    int         dc, dc2;
    int         pe;
    logic       b1;
    logic [7:0] e_fc, e_ff, e_sig;
    logic       e_pass;
    logic [7:0] r_fc, r_ff, r_sig;
    logic       r_pass;
    dut_sel = 1'b0;
    random_mask(10);
    model(1'b0, e_fc, e_ff, e_sig, e_pass);
    do_run(1'b0, 0, dc, pe, b1);
    r_fc   = fail_count;
    r_ff   = first_fail;
    r_sig  = signature;
    r_pass = pass;
    checks++; if (r_fc !== e_fc) begin errors++; $display("FAIL rr_first_fail_count: got %0d expected %0d", r_fc, e_fc); end
    mode  = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pattern !== 8'h01) begin errors++; $display("FAIL rr_async_pattern: got %h expected 01", pattern); end
    checks++; if (signature !== 8'h00) begin errors++; $display("FAIL rr_async_signature: got %h expected 00", signature); end
    checks++; if (fail_count !== 8'h00) begin errors++; $display("FAIL rr_async_fail_count: got %h expected 00", fail_count); end
    checks++; if (first_fail !== 8'hFF) begin errors++; $display("FAIL rr_async_first_fail: got %h expected ff", first_fail); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL rr_async_flags: got %b expected 000", {busy, done, pass}); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    do_run(1'b0, 0, dc2, pe, b1);
    checks++; if (dc2 != N + 3) begin errors++; $display("FAIL rr_done_cycle: got %0d expected %0d", dc2, N + 3); end
    checks++; if ({fail_count, first_fail, signature, pass} !== {r_fc, r_ff, r_sig, r_pass})
      begin errors++; $display("FAIL rr_rerun: got fc=%0d ff=%0d sig=%h pass=%b expected fc=%0d ff=%0d sig=%h pass=%b",
                               fail_count, first_fail, signature, pass, r_fc, r_ff, r_sig, r_pass); end
  endtask

  initial begin
    logic [7:0] s;
    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mode    = 1'b0;
    dut_sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      idx_of[i] = 8'h00;
      mask[i]   = 8'h00;
    end
    s = 8'h01;
    for (int i = 0; i < N; i++) begin
      pat_seq[i] = s;
      idx_of[s]  = 8'(i);
      s          = gstep(s);
    end

    test_reset();
    test_compare_pass();
    test_compare_fail();
    test_random_compare();
    test_signature();
    test_abort();
    test_reset_midrun();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
